// File: rtl/vga_plot_arbiter_pkg.sv
// Shared constants and types for the VGA plot-port arbiter (screen geometry,
// FSM state encoding, draw-engine requester indices).
package vga_arb_pkg;
  localparam int XW          = 8;
  localparam int YW          = 7;
  localparam int CW          = 3;
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int NUM_REQ_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int REQ_BG    = 0;
  localparam int REQ_SCORE = 1;
  localparam int REQ_OSU   = 2;
  localparam int REQ_LINE  = 3;
endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Draw-engine request/pixel bus plus the arbitrated VGA pixel-write port.
interface vga_plot_arbiter_if #(
  parameter int NUM_REQ = vga_arb_pkg::NUM_REQ_DEF,
  parameter int XW      = vga_arb_pkg::XW,
  parameter int YW      = vga_arb_pkg::YW,
  parameter int CW      = vga_arb_pkg::CW
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    pix_valid;
  logic [NUM_REQ*XW-1:0] x_in;
  logic [NUM_REQ*YW-1:0] y_in;
  logic [NUM_REQ*CW-1:0] colour_in;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    done;
  logic                  timeout;
  logic                  plot;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [CW-1:0]         colour;
  logic                  busy;

  modport master (
    output req, pix_valid, x_in, y_in, colour_in,
    input  grant, done, timeout, plot, x, y, colour, busy
  );

  modport slave (
    input  req, pix_valid, x_in, y_in, colour_in,
    output grant, done, timeout, plot, x, y, colour, busy
  );
endinterface

// File: rtl/vga_plot_arbiter_picker.sv
// Combinational winner select. ARB_RR_EN: search rotates from rr_ptr;
// otherwise lowest index wins.
module plot_req_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
`ifdef ARB_RR_EN
  input  logic [IW-1:0]      rr_ptr,
`endif
  input  logic [NUM_REQ-1:0] cand,
  output logic [NUM_REQ-1:0] win,
  output logic [IW-1:0]      win_idx
);
  always_comb begin
    logic [IW-1:0] j;
    logic          found;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_RR_EN
      j = IW'((int'(rr_ptr) + k) % NUM_REQ);
`else
      j = IW'(k);
`endif
      if (!found && cand[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = j;
      end
    end
  end
endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA pixel-write port among draw engines with burst grants.
// Define ARB_RR_EN for round-robin arbitration (default: fixed priority).
module vga_plot_arbiter #(
  parameter int NUM_REQ   = vga_arb_pkg::NUM_REQ_DEF,
  parameter int XW        = vga_arb_pkg::XW,
  parameter int YW        = vga_arb_pkg::YW,
  parameter int CW        = vga_arb_pkg::CW,
  parameter int MAX_BURST = 0
) (
  input logic               clk,
  input logic               resetn,
  vga_plot_arbiter_if.slave bus
);
  import vga_arb_pkg::*;

  localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 8;

  arb_state_t         state;
  logic [NUM_REQ-1:0] grant, done, mask, cand, win;
  logic [IW-1:0]      g, win_idx;
  logic [CNT_W-1:0]   cnt;
  logic               timeout, plot, busy, limit_hit;
  logic [XW-1:0]      x;
  logic [YW-1:0]      y;
  logic [CW-1:0]      colour;
`ifdef ARB_RR_EN
  logic [IW-1:0]      rr_ptr;
`endif

  // Masked engines timed out and must drop req before they can win again.
  assign cand      = bus.req & ~mask;
  assign limit_hit = (MAX_BURST != 0) && (cnt == CNT_W'(MAX_BURST - 1));

  plot_req_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
`ifdef ARB_RR_EN
    .rr_ptr  (rr_ptr),
`endif
    .cand    (cand),
    .win     (win),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_IDLE;
      grant   <= '0;
      done    <= '0;
      timeout <= 1'b0;
      plot    <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      busy    <= 1'b0;
      mask    <= '0;
      g       <= '0;
      cnt     <= '0;
`ifdef ARB_RR_EN
      rr_ptr  <= '0;
`endif
    end else begin
      done    <= '0;
      timeout <= 1'b0;
      plot    <= 1'b0;
      mask    <= mask & bus.req;
      case (state)
        ST_IDLE, ST_RELEASE: begin
          if (|cand) begin
            state <= ST_GRANT;
            grant <= win;
            g     <= win_idx;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef ARB_RR_EN
            rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
`endif
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!bus.req[g]) begin
            state <= ST_RELEASE;
            grant <= '0;
            done  <= grant;
          end else begin
            if (bus.pix_valid[g]) begin
              plot   <= 1'b1;
              x      <= bus.x_in[int'(g)*XW +: XW];
              y      <= bus.y_in[int'(g)*YW +: YW];
              colour <= bus.colour_in[int'(g)*CW +: CW];
            end
            // The final pixel of a forced end is still written above.
            if (limit_hit) begin
              state   <= ST_RELEASE;
              grant   <= '0;
              done    <= grant;
              timeout <= 1'b1;
              mask    <= (mask & bus.req) | grant;
            end else if (!(&cnt)) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant;
  assign bus.done    = done;
  assign bus.timeout = timeout;
  assign bus.plot    = plot;
  assign bus.x       = x;
  assign bus.y       = y;
  assign bus.colour  = colour;
  assign bus.busy    = busy;
endmodule
